// File: rtl/flag_register_file.sv
// rtl/flag_register_file.sv - per-register ALU flag file with write pipeline and clear sweep
//
// Holds four 16-bit flag vectors (zero, sign, overflow, error), one bit per
// architectural register, which feed the jump decoder directly.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-high reset
//   wr_valid       ALU result write request
//   wr_ready       write accepted when wr_valid && wr_ready at a rising edge
//   wr_reg         destination register index (4 bits)
//   wr_data        ALU result value (16 bits)
//   wr_overflow    ALU overflow for this result
//   wr_error       ALU error (e.g. divide by zero) for this result
//   clr_req        request to clear all flags (sweep of 16 cycles)
//   clr_busy       high while the clear sweep runs
//   flags_pending  high while an accepted write has not yet updated the flags
//   zeroflag, signflag, overflow, errorbit
//                  per-register flags, bit r for register r
//
// Configuration macro:
//   STICKY_ERROR_EN  when defined, a commit ORs the error into errorbit[r];
//                    the bit then clears only by the sweep or by reset.
//                    When undefined, a commit writes errorbit[r] directly.

module flag_register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_reg,
    input  logic [15:0] wr_data,
    input  logic        wr_overflow,
    input  logic        wr_error,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        flags_pending,
    output logic [15:0] zeroflag,
    output logic [15:0] signflag,
    output logic [15:0] overflow,
    output logic [15:0] errorbit
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  idx;

    // Stage 1 of the write pipeline: captured at acceptance, committed next edge.
    logic        s1_valid;
    logic [3:0]  s1_reg;
    logic        s1_zero;
    logic        s1_sign;
    logic        s1_overflow;
    logic        s1_error;

    logic        wr_accept;

    // clr_req blocks acceptance in the same cycle so a write can never slip in
    // behind the sweep. The reset term keeps wr_ready low while reset is held.
    assign wr_ready      = !reset && (state == ST_IDLE) && !clr_req;
    assign wr_accept     = wr_valid && wr_ready;
    assign clr_busy      = (state == ST_CLEAR);
    assign flags_pending = s1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= 4'd0;
            s1_valid    <= 1'b0;
            s1_reg      <= 4'd0;
            s1_zero     <= 1'b0;
            s1_sign     <= 1'b0;
            s1_overflow <= 1'b0;
            s1_error    <= 1'b0;
            zeroflag    <= 16'h0000;
            signflag    <= 16'h0000;
            overflow    <= 16'h0000;
            errorbit    <= 16'h0000;
        end else begin
            // Stage 1 capture. Zero/sign are reduced here so the commit edge
            // only has to steer single bits.
            s1_valid <= wr_accept;
            if (wr_accept) begin
                s1_reg      <= wr_reg;
                s1_zero     <= (wr_data == 16'h0000);
                s1_sign     <= wr_data[15];
                s1_overflow <= wr_overflow;
                s1_error    <= wr_error;
            end

            // Commit. A write in flight when CLEAR is entered commits on the
            // entry edge; no new write can be accepted during CLEAR, so a
            // commit never coincides with a sweep step.
            if (s1_valid) begin
                zeroflag[s1_reg] <= s1_zero;
                signflag[s1_reg] <= s1_sign;
                overflow[s1_reg] <= s1_overflow;
`ifdef STICKY_ERROR_EN
                errorbit[s1_reg] <= errorbit[s1_reg] | s1_error;
`else
                errorbit[s1_reg] <= s1_error;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        idx   <= 4'd0;
                    end
                end
                ST_CLEAR: begin
                    // One register per edge, r0 first; clr_req is ignored here.
                    zeroflag[idx] <= 1'b0;
                    signflag[idx] <= 1'b0;
                    overflow[idx] <= 1'b0;
                    errorbit[idx] <= 1'b0;
                    idx           <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
